// File: rtl/pe_acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_acc_ctrl_pkg
//  Description : Shared NPU constants and per-state output bundle type used by
//                the PE accumulator controller.
//  Revision    : 1.0  initial release
// ============================================================================
package pe_acc_ctrl_pkg;

    localparam int NPU_LEN_W = 16;

    // Registered control outputs that depend only on the controller state.
    typedef struct packed {
        logic cmd_rdy;
        logic acc_clear;
        logic acc_en;
        logic src_rdy;
        logic res_vld;
        logic busy;
    } ctrl_out_t;

    localparam ctrl_out_t C_OUTS_IDLE = '{cmd_rdy: 1'b1, acc_clear: 1'b1, acc_en: 1'b0,
                                          src_rdy: 1'b0, res_vld: 1'b0, busy: 1'b0};
    localparam ctrl_out_t C_OUTS_ACC  = '{cmd_rdy: 1'b0, acc_clear: 1'b0, acc_en: 1'b1,
                                          src_rdy: 1'b1, res_vld: 1'b0, busy: 1'b1};
    localparam ctrl_out_t C_OUTS_DONE = '{cmd_rdy: 1'b0, acc_clear: 1'b0, acc_en: 1'b1,
                                          src_rdy: 1'b0, res_vld: 1'b1, busy: 1'b1};

endpackage : pe_acc_ctrl_pkg
`default_nettype wire

// File: rtl/pe_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pe_acc_ctrl
//  Description : Job controller sequencing clear/enable/data-valid of an
//                external accumulator over a counted burst of data beats.
//  Revision    : 1.0  initial release
// ============================================================================
module pe_acc_ctrl
    import pe_acc_ctrl_pkg::*;
#(
    parameter int LEN_W = NPU_LEN_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_vld,
    output logic             o_cmd_rdy,
    input  logic [LEN_W-1:0] i_cmd_len,
    input  logic             i_abort,
    input  logic             i_src_vld,
    output logic             o_src_rdy,
    output logic             o_acc_clear,
    output logic             o_acc_en,
    output logic             o_mdata_vld,
    output logic             o_res_vld,
    input  logic             i_res_rdy,
    output logic             o_busy,
    output logic [LEN_W-1:0] o_beat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    ctrl_out_t        outs_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;

    logic             w_cmd_fire;
    logic             w_beat_fire;
    logic [LEN_W-1:0] w_cnt_inc;

    // Abort in IDLE withholds ready so the requester sees no handshake.
    assign o_cmd_rdy   = outs_q.cmd_rdy & ~i_abort;
    assign o_acc_clear = outs_q.acc_clear;
    assign o_acc_en    = outs_q.acc_en;
    assign o_src_rdy   = outs_q.src_rdy;
    assign o_res_vld   = outs_q.res_vld;
    assign o_busy      = outs_q.busy;
    assign o_mdata_vld = outs_q.src_rdy & i_src_vld;
    assign o_beat_cnt  = cnt_q;

    assign w_cmd_fire  = i_cmd_vld & o_cmd_rdy;
    assign w_beat_fire = outs_q.src_rdy & i_src_vld;
    assign w_cnt_inc   = cnt_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            outs_q  <= C_OUTS_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        len_q <= i_cmd_len;
                        cnt_q <= '0;
                        // Zero-length jobs report the already-cleared accumulator.
                        if (i_cmd_len == '0) begin
                            state_q <= S_DONE;
                            outs_q  <= C_OUTS_DONE;
                        end else begin
                            state_q <= S_ACC;
                            outs_q  <= C_OUTS_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (i_abort) begin
                        state_q <= S_IDLE;
                        outs_q  <= C_OUTS_IDLE;
                    end else if (w_beat_fire) begin
                        cnt_q <= w_cnt_inc;
                        if (w_cnt_inc == len_q) begin
                            state_q <= S_DONE;
                            outs_q  <= C_OUTS_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (i_abort || i_res_rdy) begin
                        state_q <= S_IDLE;
                        outs_q  <= C_OUTS_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    outs_q  <= C_OUTS_IDLE;
                end
            endcase
        end
    end

endmodule : pe_acc_ctrl
`default_nettype wire

// File: tb/tb_pe_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_acc_ctrl
//  Description : Self-checking bench for pe_acc_ctrl with a behavioural
//                accumulator lane beside the controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pe_acc_ctrl;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_vld;
    logic [LEN_W-1:0] cmd_len;
    logic             abort;
    logic             src_vld;
    logic             res_rdy;
    logic [15:0]      src_data;

    logic             o_cmd_rdy, o_src_rdy, o_acc_clear, o_acc_en;
    logic             o_mdata_vld, o_res_vld, o_busy;
    logic [LEN_W-1:0] o_beat_cnt;

    logic [15:0]      acc;
    logic [15:0]      beat_data [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_acc_ctrl #(.LEN_W(LEN_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_vld   (cmd_vld),
        .o_cmd_rdy   (o_cmd_rdy),
        .i_cmd_len   (cmd_len),
        .i_abort     (abort),
        .i_src_vld   (src_vld),
        .o_src_rdy   (o_src_rdy),
        .o_acc_clear (o_acc_clear),
        .o_acc_en    (o_acc_en),
        .o_mdata_vld (o_mdata_vld),
        .o_res_vld   (o_res_vld),
        .i_res_rdy   (res_rdy),
        .o_busy      (o_busy),
        .o_beat_cnt  (o_beat_cnt)
    );

    // Accumulator lane as wired at integration level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               acc <= '0;
        else if (o_acc_clear)     acc <= '0;
        else if (o_acc_en && o_mdata_vld) acc <= acc + src_data;
    end

    typedef struct {
        int          len;
        logic [15:0] d0, d1, d2, d3;
        logic [15:0] gaps;
        int          hold;
        logic [15:0] exp_sum;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_job(input int len, input logic [15:0] gaps, input int hold,
                          input logic [15:0] exp_sum);
        int beats = 0;
        int c = 0;
        @(negedge clk);
        check("idle_cmd_rdy", o_cmd_rdy, 1);
        check("idle_acc_clear", o_acc_clear, 1);
        check("idle_busy", o_busy, 0);
        cmd_vld = 1'b1;
        cmd_len = LEN_W'(len);
        @(negedge clk);
        cmd_vld = 1'b0;
        check("accept_busy", o_busy, 1);
        check("accept_cnt", o_beat_cnt, 0);
        check("accept_cmd_rdy", o_cmd_rdy, 0);
        check("accept_acc_en", o_acc_en, 1);
        check("accept_src_rdy", o_src_rdy, (len != 0) ? 1 : 0);
        while (beats < len && c < 200) begin
            if (c < 16 && gaps[c]) begin
                src_vld  = 1'b0;
                src_data = 16'hDEAD;
            end else begin
                src_vld  = 1'b1;
                src_data = beat_data[beats];
            end
            #1 check("mdata_vld", o_mdata_vld, src_vld);
            @(negedge clk);
            if (src_vld) beats++;
            src_vld = 1'b0;
            c++;
            check("beat_cnt", o_beat_cnt, beats);
        end
        if (beats < len) check("beat_timeout", beats, len);
        check("done_res_vld", o_res_vld, 1);
        check("done_src_rdy", o_src_rdy, 0);
        check("done_sum", acc, exp_sum);
        check("done_cnt", o_beat_cnt, len);
        for (int h = 0; h < hold; h++) begin
            cmd_vld  = 1'b1;
            cmd_len  = 16'd5;
            src_vld  = 1'b1;
            src_data = 16'h1234;
            #1 check("done_cmd_rdy", o_cmd_rdy, 0);
            check("done_mdata_vld", o_mdata_vld, 0);
            @(negedge clk);
            check("hold_res_vld", o_res_vld, 1);
            check("hold_sum", acc, exp_sum);
        end
        cmd_vld = 1'b0;
        src_vld = 1'b0;
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        check("post_res_vld", o_res_vld, 0);
        check("post_busy", o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_vld = 1'b0; cmd_len = '0; abort = 1'b0;
        src_vld = 1'b0; res_rdy = 1'b0; src_data = '0;

        vecs[0] = '{len: 4, d0: 16'd1,    d1: 16'd2,    d2: 16'd3, d3: 16'd4,
                    gaps: 16'h0000, hold: 0, exp_sum: 16'd10};
        vecs[1] = '{len: 3, d0: 16'hFFFB, d1: 16'hFFFB, d2: 16'd2, d3: 16'd0,
                    gaps: 16'h0015, hold: 1, exp_sum: 16'hFFF8};
        vecs[2] = '{len: 0, d0: 16'd9,    d1: 16'd9,    d2: 16'd9, d3: 16'd9,
                    gaps: 16'h0000, hold: 2, exp_sum: 16'd0};
        vecs[3] = '{len: 2, d0: 16'd127,  d1: 16'd127,  d2: 16'd0, d3: 16'd0,
                    gaps: 16'h0002, hold: 5, exp_sum: 16'd254};
        vecs[4] = '{len: 1, d0: 16'd7,    d1: 16'd0,    d2: 16'd0, d3: 16'd0,
                    gaps: 16'h0000, hold: 0, exp_sum: 16'd7};

        repeat (2) @(negedge clk);
        check("rst_cmd_rdy", o_cmd_rdy, 1);
        check("rst_acc_clear", o_acc_clear, 1);
        check("rst_acc_en", o_acc_en, 0);
        check("rst_res_vld", o_res_vld, 0);
        check("rst_cnt", o_beat_cnt, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            beat_data[0] = vecs[i].d0; beat_data[1] = vecs[i].d1;
            beat_data[2] = vecs[i].d2; beat_data[3] = vecs[i].d3;
            do_job(vecs[i].len, vecs[i].gaps, vecs[i].hold, vecs[i].exp_sum);
        end

        // Abort on beat 2 of a 4-beat job, then a clean 1-beat job.
        @(negedge clk);
        cmd_vld = 1'b1; cmd_len = 16'd4;
        @(negedge clk);
        cmd_vld = 1'b0; src_vld = 1'b1; src_data = 16'd1;
        @(negedge clk);
        src_data = 16'd2; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; src_vld = 1'b0;
        check("abort_busy", o_busy, 0);
        check("abort_res_vld", o_res_vld, 0);
        check("abort_src_rdy", o_src_rdy, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_res", o_res_vld, 0);
        end
        beat_data[0] = 16'd7;
        do_job(1, 16'h0000, 0, 16'd7);

        // Abort in IDLE blocks acceptance.
        @(negedge clk);
        cmd_vld = 1'b1; cmd_len = 16'd2; abort = 1'b1;
        #1 check("idle_abort_rdy", o_cmd_rdy, 0);
        @(negedge clk);
        cmd_vld = 1'b0; abort = 1'b0;
        check("idle_abort_busy", o_busy, 0);

        // Abort in DONE drops the result.
        cmd_vld = 1'b1; cmd_len = 16'd0;
        @(negedge clk);
        cmd_vld = 1'b0;
        check("len0_done", o_res_vld, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("done_abort_res", o_res_vld, 0);
        check("done_abort_busy", o_busy, 0);

        // Abort coincident with last beat wins.
        @(negedge clk);
        cmd_vld = 1'b1; cmd_len = 16'd1;
        @(negedge clk);
        cmd_vld = 1'b0; src_vld = 1'b1; src_data = 16'd9; abort = 1'b1;
        @(negedge clk);
        src_vld = 1'b0; abort = 1'b0;
        check("last_abort_res", o_res_vld, 0);
        check("last_abort_busy", o_busy, 0);

        // Asynchronous reset mid-ACC.
        @(negedge clk);
        cmd_vld = 1'b1; cmd_len = 16'd4;
        @(negedge clk);
        cmd_vld = 1'b0; src_vld = 1'b1; src_data = 16'd50;
        repeat (2) @(negedge clk);
        src_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_clear", o_acc_clear, 1);
        check("mid_rst_en", o_acc_en, 0);
        check("mid_rst_cnt", o_beat_cnt, 0);
        check("mid_rst_src_rdy", o_src_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        beat_data[0] = 16'd1; beat_data[1] = 16'd2; beat_data[2] = 16'd3; beat_data[3] = 16'd4;
        do_job(4, 16'h0000, 0, 16'd10);

        // Randomised jobs against a sum-of-beats reference.
        for (int j = 0; j < 20; j++) begin
            int          len;
            logic [15:0] sum;
            logic [7:0]  b;
            len = int'($urandom_range(0, 12));
            sum = '0;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                beat_data[i] = {{8{b[7]}}, b};
                sum = sum + beat_data[i];
            end
            do_job(len, 16'($urandom), int'($urandom_range(0, 3)), sum);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pe_acc_ctrl
`default_nettype wire
